spmv_mac_lanes: RTL and testbench

- Parametrised multi-lane multiply-accumulate engine for the SpMV datapath; fixed-point/integer successor to the single-lane MAC.
- Each beat carries up to LANES matrix values and the matching gathered vector elements. Unmasked products are reduced by an adder tree and accumulated into a row sum.
- A row-end flag closes the row and emits one result (sum, nonzero count, overflow flag) on a valid/ready output.
- Sits between the column-gather unit and the row-result writer.

---
 rtl/spmv_mac_lanes.sv | 198 +++++++++++++++++++
 tb/tb_spmv_mac_lanes.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_mac_lanes.sv
// spmv_mac_lanes: multi-lane multiply-accumulate engine for the SpMV datapath.
// Three pipeline stages: per-lane multiply, adder-tree reduce, row accumulate.
// One global advance enable stalls every stage together, so backpressure from
// the row-result writer never drops or duplicates a beat.
module spmv_mac_lanes #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH,
    parameter int FRAC_BITS  = 0,
    parameter int SATURATE   = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LANES*DATA_WIDTH-1:0] in_val,
    input  logic [LANES*DATA_WIDTH-1:0] in_vec,
    input  logic [LANES-1:0]            in_mask,
    input  logic                        in_last,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [ACC_WIDTH-1:0]        out_acc,
    output logic [CNT_WIDTH-1:0]        out_count,
    output logic                        out_overflow,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int LG = $clog2(LANES);
    localparam int PW = 2*DATA_WIDTH;
    // Tree width holds the worst-case sum of all lanes without truncation.
    localparam int TW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + LG + 1;
    // One guard bit above the tree so acc + tree_sum can never wrap.
    localparam int GW = TW + 1;
    localparam int NW = LG + 1;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ------------------------------------------------------------------
    // S1: per-lane scaled products
    // ------------------------------------------------------------------
    logic [LANES*PW-1:0] prod_next;
    logic [NW-1:0]       pop_next;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [DATA_WIDTH-1:0] a;
            logic signed [DATA_WIDTH-1:0] b;
            logic signed [PW-1:0]         full;
            logic signed [PW-1:0]         scaled;
            assign a      = in_val[gi*DATA_WIDTH +: DATA_WIDTH];
            assign b      = in_vec[gi*DATA_WIDTH +: DATA_WIDTH];
            assign full   = PW'(a) * PW'(b);
            // Shift kept in its own signed net so it stays arithmetic.
            assign scaled = full >>> FRAC_BITS;
            assign prod_next[gi*PW +: PW] = in_mask[gi] ? scaled : '0;
        end
    endgenerate

    // Count of real nonzeros in this beat.
    always_comb begin
        pop_next = '0;
        for (int i = 0; i < LANES; i++) begin
            pop_next = pop_next + NW'(in_mask[i]);
        end
    end

    logic                s1_valid;
    logic                s1_last;
    logic [NW-1:0]       s1_pop;
    logic [LANES*PW-1:0] s1_prod;

    // Stage-1 register: products plus beat control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_pop   <= '0;
            s1_prod  <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            s1_pop   <= pop_next;
            s1_prod  <= prod_next;
        end
    end

    // ------------------------------------------------------------------
    // S2: binary adder tree, leaves at LANES-1 .. 2*LANES-2, root at 0
    // ------------------------------------------------------------------
    logic [TW-1:0] node [2*LANES-1];
    logic [TW-1:0] tree_sum;

    // Sign-extend each product into the tree and reduce pairwise upward.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            node[LANES-1+i] = {{(TW-PW){s1_prod[i*PW+PW-1]}}, s1_prod[i*PW +: PW]};
        end
        for (int n = LANES-2; n >= 0; n--) begin
            node[n] = node[2*n+1] + node[2*n+2];
        end
        tree_sum = node[0];
    end

    logic          s2_valid;
    logic          s2_last;
    logic [NW-1:0] s2_pop;
    logic [TW-1:0] s2_sum;

    // Stage-2 register: reduced beat sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_pop   <= '0;
            s2_sum   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_pop   <= s1_pop;
            s2_sum   <= tree_sum;
        end
    end

    // ------------------------------------------------------------------
    // S3: row accumulate with range check
    // ------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] acc_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic                 ovf_reg;
    logic                 first_reg;

    logic [GW-1:0]        base_g;
    logic [GW-1:0]        sum_g;
    logic [GW-ACC_WIDTH:0] top_bits;
    logic                 ovf_now;
    logic [ACC_WIDTH-1:0] acc_res;
    logic [CNT_WIDTH-1:0] cnt_base;
    logic [CNT_WIDTH:0]   cnt_sum;
    logic [CNT_WIDTH-1:0] cnt_res;
    logic                 ovf_res;

    // Next row state: first beat of a row starts from zero instead of acc_reg.
    always_comb begin
        base_g   = first_reg ? '0 : {{(GW-ACC_WIDTH){acc_reg[ACC_WIDTH-1]}}, acc_reg};
        sum_g    = base_g + {{(GW-TW){s2_sum[TW-1]}}, s2_sum};
        // In range only when every bit from the ACC sign bit upward agrees.
        top_bits = sum_g[GW-1:ACC_WIDTH-1];
        ovf_now  = !((&top_bits) || (~|top_bits));
        if (ovf_now && (SATURATE != 0)) begin
            acc_res = sum_g[GW-1] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_res = sum_g[ACC_WIDTH-1:0];
        end
        cnt_base = first_reg ? '0 : cnt_reg;
        cnt_sum  = {1'b0, cnt_base} + (CNT_WIDTH+1)'(s2_pop);
        cnt_res  = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
        ovf_res  = (first_reg ? 1'b0 : ovf_reg) | ovf_now;
    end

    // Row state and result register; a last beat publishes and re-arms the row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg      <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            first_reg    <= 1'b1;
            out_acc      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
            out_valid    <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid && s2_last;
            if (s2_valid) begin
                if (s2_last) begin
                    out_acc      <= acc_res;
                    out_count    <= cnt_res;
                    out_overflow <= ovf_res;
                    acc_reg      <= '0;
                    cnt_reg      <= '0;
                    ovf_reg      <= 1'b0;
                    first_reg    <= 1'b1;
                end else begin
                    acc_reg      <= acc_res;
                    cnt_reg      <= cnt_res;
                    ovf_reg      <= ovf_res;
                    first_reg    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spmv_mac_lanes.sv
// Bench for spmv_mac_lanes: four instances (integer, fixed-point, 8-bit
// saturating, 8-bit wrapping) checked against a behavioural row model through
// per-instance scoreboards.
module tb_spmv_mac_lanes;

    typedef struct {
        logic signed [127:0] acc;
        int                  cnt;
        bit                  ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic out_ready = 1'b1;

    // Stream A: 32-bit data, instances a (FRAC 0) and f (FRAC 4)
    logic [127:0] val_a, vec_a;
    logic [3:0]   mask_a;
    logic         last_a, valid_a;
    logic         ir_a, ir_f, ov_a, ov_f, ovf_a, ovf_f;
    logic [63:0]  acc_a, acc_f;
    logic [15:0]  cnt_a, cnt_f;

    // Stream B: 8-bit data, 16-bit accumulator, instances s (saturate) and w (wrap)
    logic [31:0]  val_b, vec_b;
    logic [3:0]   mask_b;
    logic         last_b, valid_b;
    logic         ir_s, ir_w, ov_s, ov_w, ovf_s, ovf_w;
    logic [15:0]  acc_s, acc_w;
    logic [15:0]  cnt_s, cnt_w;

    int n_vec = 0;
    int n_err = 0;

    exp_t qa[$], qf[$], qs[$], qw[$];
    logic signed [127:0] m_acc [4];
    int                  m_cnt [4];
    bit                  m_ovf [4];
    bit                  m_first [4];

    always #5 clk = ~clk;

    spmv_mac_lanes #(.LANES(4), .DATA_WIDTH(32), .FRAC_BITS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_val(val_a), .in_vec(vec_a), .in_mask(mask_a),
        .in_last(last_a), .in_valid(valid_a), .in_ready(ir_a), .out_acc(acc_a),
        .out_count(cnt_a), .out_overflow(ovf_a), .out_valid(ov_a), .out_ready(out_ready));

    spmv_mac_lanes #(.LANES(4), .DATA_WIDTH(32), .FRAC_BITS(4)) dut_f (
        .clk(clk), .rst_n(rst_n), .in_val(val_a), .in_vec(vec_a), .in_mask(mask_a),
        .in_last(last_a), .in_valid(valid_a), .in_ready(ir_f), .out_acc(acc_f),
        .out_count(cnt_f), .out_overflow(ovf_f), .out_valid(ov_f), .out_ready(out_ready));

    spmv_mac_lanes #(.LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_val(val_b), .in_vec(vec_b), .in_mask(mask_b),
        .in_last(last_b), .in_valid(valid_b), .in_ready(ir_s), .out_acc(acc_s),
        .out_count(cnt_s), .out_overflow(ovf_s), .out_valid(ov_s), .out_ready(out_ready));

    spmv_mac_lanes #(.LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(16), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_val(val_b), .in_vec(vec_b), .in_mask(mask_b),
        .in_last(last_b), .in_valid(valid_b), .in_ready(ir_w), .out_acc(acc_w),
        .out_count(cnt_w), .out_overflow(ovf_w), .out_valid(ov_w), .out_ready(out_ready));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic void reset_model();
        for (int d = 0; d < 4; d++) begin
            m_acc[d] = 0; m_cnt[d] = 0; m_ovf[d] = 1'b0; m_first[d] = 1'b1;
        end
    endfunction

    // Behavioural row model: exact product sum, then range handling per config.
    function automatic void model_beat(input int d, input int v[4], input int w[4],
                                       input logic [3:0] m, input bit last,
                                       input int accw, input int frac, input bit sat);
        logic signed [127:0] p, tree, s, maxv, minv, modv;
        int c, cnt;
        bit ovf;
        exp_t e;
        tree = 0; c = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                p = v[i];
                p = p * w[i];
                p = p >>> frac;
                tree = tree + p;
                c++;
            end
        end
        s    = (m_first[d] ? 128'sd0 : m_acc[d]) + tree;
        maxv = (128'sd1 <<< (accw-1)) - 1;
        minv = -maxv - 1;
        ovf  = m_first[d] ? 1'b0 : m_ovf[d];
        if (s > maxv || s < minv) begin
            ovf = 1'b1;
            if (sat) begin
                s = (s > maxv) ? maxv : minv;
            end else begin
                modv = 128'sd1 <<< accw;
                s = s & (modv - 1);
                if (s > maxv) s = s - modv;
            end
        end
        cnt = (m_first[d] ? 0 : m_cnt[d]) + c;
        if (cnt > 65535) cnt = 65535;
        if (last) begin
            e.acc = s; e.cnt = cnt; e.ovf = ovf;
            case (d)
                0: qa.push_back(e);
                1: qf.push_back(e);
                2: qs.push_back(e);
                default: qw.push_back(e);
            endcase
            m_acc[d] = 0; m_cnt[d] = 0; m_ovf[d] = 1'b0; m_first[d] = 1'b1;
        end else begin
            m_acc[d] = s; m_cnt[d] = cnt; m_ovf[d] = ovf; m_first[d] = 1'b0;
        end
    endfunction

    // Pop the oldest expected row of instance d and compare it with the output.
    task automatic take(input int d, input string nm, input logic [127:0] acc,
                        input int cnt, input bit ovf);
        exp_t e;
        int sz;
        case (d)
            0: sz = qa.size();
            1: sz = qf.size();
            2: sz = qs.size();
            default: sz = qw.size();
        endcase
        if (sz == 0) begin
            check({nm, "_unexpected_result"}, 1, 0);
            return;
        end
        case (d)
            0: e = qa.pop_front();
            1: e = qf.pop_front();
            2: e = qs.pop_front();
            default: e = qw.pop_front();
        endcase
        $display("result %s: acc=%0d count=%0d ovf=%0d", nm, $signed(acc), cnt, ovf);
        check({nm, "_acc"}, acc, e.acc);
        check({nm, "_count"}, cnt, e.cnt);
        check({nm, "_ovf"}, {127'd0, ovf}, {127'd0, e.ovf});
    endtask

    // Output monitor: consume on handshake, verify results are held while stalled.
    bit held_a = 1'b0;
    logic [127:0] hacc_a;
    always @(negedge clk) begin
        if (rst_n && out_ready) begin
            if (ov_a) take(0, "a", {{64{acc_a[63]}}, acc_a}, int'(cnt_a), ovf_a);
            if (ov_f) take(1, "f", {{64{acc_f[63]}}, acc_f}, int'(cnt_f), ovf_f);
            if (ov_s) take(2, "s", {{112{acc_s[15]}}, acc_s}, int'(cnt_s), ovf_s);
            if (ov_w) take(3, "w", {{112{acc_w[15]}}, acc_w}, int'(cnt_w), ovf_w);
        end
        if (rst_n && ov_a && !out_ready) begin
            if (held_a) check("a_hold_acc", {{64{acc_a[63]}}, acc_a}, hacc_a);
            held_a = 1'b1;
            hacc_a = {{64{acc_a[63]}}, acc_a};
        end else begin
            held_a = 1'b0;
        end
    end

    // Present one beat on stream A; returns just after the accepting edge.
    task automatic drive_a(input int v[4], input int w[4], input logic [3:0] m, input bit last);
        bit ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            val_a[i*32 +: 32] = v[i];
            vec_a[i*32 +: 32] = w[i];
        end
        mask_a = m; last_a = last; valid_a = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ir_a && ir_f) begin ok = 1'b1; break; end
        end
        if (!ok) check("a_accept_timeout", 0, 1);
        else begin
            model_beat(0, v, w, m, last, 64, 0, 1'b1);
            model_beat(1, v, w, m, last, 64, 4, 1'b1);
        end
        @(posedge clk); #1;
        valid_a = 1'b0;
    endtask

    task automatic drive_b(input int v[4], input int w[4], input logic [3:0] m, input bit last);
        bit ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            val_b[i*8 +: 8] = v[i][7:0];
            vec_b[i*8 +: 8] = w[i][7:0];
        end
        mask_b = m; last_b = last; valid_b = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ir_s && ir_w) begin ok = 1'b1; break; end
        end
        if (!ok) check("b_accept_timeout", 0, 1);
        else begin
            model_beat(2, v, w, m, last, 16, 0, 1'b1);
            model_beat(3, v, w, m, last, 16, 0, 1'b0);
        end
        @(posedge clk); #1;
        valid_b = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (qa.size() + qf.size() + qs.size() + qw.size() == 0) break;
        end
        check("drain_pending", qa.size() + qf.size() + qs.size() + qw.size(), 0);
        @(posedge clk); #1;
    endtask

    bit saw_low;

    initial begin
        val_a = '0; vec_a = '0; mask_a = '0; last_a = 1'b0; valid_a = 1'b0;
        val_b = '0; vec_b = '0; mask_b = '0; last_b = 1'b0; valid_b = 1'b0;
        reset_model();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_a_valid", ov_a, 0);
        check("rst_a_acc", acc_a, 0);
        check("rst_a_count", cnt_a, 0);
        check("rst_a_ovf", ovf_a, 0);
        check("rst_s_valid", ov_s, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", ir_a, 1);
        @(posedge clk); #1;

        // Single full beat and its latency
        drive_a('{1, 2, 3, 4}, '{5, 6, 7, 8}, 4'hF, 1'b1);
        @(negedge clk); check("lat_cycle1", ov_a, 0);
        @(negedge clk); check("lat_cycle2", ov_a, 0);
        @(negedge clk); check("lat_cycle3", ov_a, 1);
        @(posedge clk); #1;

        // Three-beat row with partial masks, then a single-beat row back to back
        drive_a('{2, 2, 2, 2}, '{3, 3, 3, 3}, 4'hF, 1'b0);
        drive_a('{2, 2, 2, 2}, '{3, 3, 3, 3}, 4'h3, 1'b0);
        drive_a('{2, 2, 2, 2}, '{3, 3, 3, 3}, 4'h0, 1'b1);
        drive_a('{-1, 0, 0, 0}, '{10, 0, 0, 0}, 4'h1, 1'b1);
        // Fixed-point truncation toward -inf
        drive_a('{-1, 0, 0, 0}, '{1, 0, 0, 0}, 4'h1, 1'b1);
        drain();

        // Positive overflow, negative overflow, all-masked row
        drive_b('{127, 127, 127, 127}, '{127, 127, 127, 127}, 4'hF, 1'b0);
        drive_b('{127, 127, 127, 127}, '{127, 127, 127, 127}, 4'hF, 1'b0);
        drive_b('{127, 127, 127, 127}, '{127, 127, 127, 127}, 4'hF, 1'b1);
        drive_b('{-128, -128, -128, -128}, '{127, 127, 127, 127}, 4'hF, 1'b0);
        drive_b('{-128, -128, -128, -128}, '{127, 127, 127, 127}, 4'hF, 1'b1);
        drive_b('{5, 6, 7, 8}, '{9, 9, 9, 9}, 4'h0, 1'b1);
        drive_b('{-3, 4, 0, 100}, '{7, -2, 5, 1}, 4'hB, 1'b1);
        drain();

        // Backpressure: five single-beat rows against a 10-cycle stall
        saw_low = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    drive_a('{k, 1, 0, 0}, '{k + 1, 2, 0, 0}, 4'h3, 1'b1);
                end
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (!ir_a) saw_low = 1'b1;
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        check("bp_in_ready_dropped", saw_low, 1);
        drain();

        // Reset in the middle of a row with a beat in flight
        drive_a('{9, 9, 9, 9}, '{9, 9, 9, 9}, 4'hF, 1'b0);
        drive_a('{7, 7, 7, 7}, '{7, 7, 7, 7}, 4'hF, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", ov_a, 0);
        check("mid_rst_acc", acc_a, 0);
        check("mid_rst_count", cnt_a, 0);
        check("mid_rst_ovf", ovf_a, 0);
        check("mid_rst_in_ready", ir_a, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        reset_model();
        drive_a('{2, 0, 0, 0}, '{3, 0, 0, 0}, 4'h1, 1'b1);
        drain();

        check("sb_a_left", qa.size(), 0);
        check("sb_f_left", qf.size(), 0);
        check("sb_s_left", qs.size(), 0);
        check("sb_w_left", qw.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
